usb_key_queue: RTL
==================

// Module: usb_key_queue
// PURPOSE
//  Keyboard event queue for the USB HID path, all in the clkusb_i domain. Takes raw HID host
//  reports, finds new key presses across all NKEYS slots and converts them to characters.
//  Auto-repeats the most recent held key and buffers events in a DEPTH-entry FWFT FIFO.
//  Replaces the single new_key/keyascii latch; the CPU-side register file pops entries.
// PARAMETERS
//  NKEYS        4        scancode slots examined per report (1..6)
//  DEPTH        8        FIFO entries; power of two, >=2
//  CNT_W        23       repeat counter width
//  FIRST_REPEAT 8000000  clkusb_i cycles from new press to first repeat
//  REPEAT_RATE  1200000  clkusb_i cycles between subsequent repeats
// PORTS
//  clkusb_i        in   1              USB clock; sole clock of the block
//  rst_n_i         in   1              asynchronous, active-low reset
//  report_i        in   1              one-cycle pulse: HID report fields valid
//  typ_i           in   2              device type (0 none, 1 kbd, 2 mouse, 3 pad)
//  key_modifiers_i in   8              HID modifier byte
//  keys_i          in   8*NKEYS        slot k at [8k+7:8k]; 0 = empty
//  repeat_en_i     in   1              1 = auto-repeat enabled
//  pop_i           in   1              consume head entry (ignored when empty)
//  clr_ovf_i       in   1              clear sticky overflow
//  data_o          out  16             head entry {scancode[15:8], char[7:0]}
//  valid_o         out  1              FIFO not empty
//  count_o         out  $clog2(DEPTH)+1  current occupancy
//  overflow_o      out  1              sticky: an event was dropped
// BEHAVIOUR
//  - Reset: data_o=0, valid_o=0, count_o=0, overflow_o=0. prev set, pending and rpt_key
//    cleared; counter=FIRST_REPEAT; FSM=IDLE. Reset mid-scan discards everything.
//  - Accept a report only when report_i=1 and typ_i==1. Ignore it entirely if any slot==8'h01
//    (ErrorRollOver); prev set is unchanged.
//  - FSM IDLE -> SCAN on an accepted report (or held pending). Snapshot keys and modifiers.
//    In SCAN, slot i is checked at idx=i, one slot per cycle, in ascending order.
//  - Slot i is a new press if it is !=0 and not in the prev set (all NKEYS slots of the last
//    accepted report). Push {sc, scancode2char(sc, snap_mod)}; char may be 0 (unmapped).
//  - On a new press: rpt_key<=sc, counter<=FIRST_REPEAT. The last new press in the scan wins.
//  - At idx=NKEYS-1: prev set<=snapshot. Clear rpt_key if it is absent from the snapshot.
//    Then go to IDLE, or straight to SCAN if a report is pending.
//  - Report during SCAN: latch into a 1-deep pending buffer; a later report overwrites it.
//  - Latency: report pulse at T -> slot i pushed at T+1+i -> valid_o/count_o update at T+2+i.
//  - Repeat, counted only in IDLE: when rpt_key!=0 and repeat_en_i=1, counter decrements.
//    At 0: push {rpt_key, scancode2char(rpt_key, prev-report modifiers)}, counter<=REPEAT_RATE.
//    repeat_en_i=0 freezes the counter.
//  - typ_i !=1 for any cycle: clear prev set and rpt_key, abort SCAN and drop pending.
//    FIFO contents are kept.
//  - FIFO is first-word-fall-through: data_o shows the head whenever valid_o=1. pop_i with
//    valid_o=1 advances the head on the next edge. When empty, data_o holds its last value.
//  - Push when full with no pop: entry dropped, overflow_o<=1. Push+pop when full: both
//    accepted, count unchanged. Push+pop when empty: push accepted, pop ignored.
//  - overflow_o is cleared by clr_ovf_i. If clr and a new drop fall in the same cycle, set wins.
//  - Pointers wrap modulo DEPTH; count_o ranges 0..DEPTH.
// STRUCTURE
//  - Package usb_hid_pkg: TYP_NONE/KBD/MOUSE/PAD, SHIFT_MASK=8'h22, CTRL_MASK=8'h11,
//    KEY_ROLLOVER=8'h01, arrow codes 136..139, function scancode2char.
//  - Sub-module usb_sync_fifo #(WIDTH, DEPTH): FWFT, full/empty/count. Scan FSM, repeat
//    counter and overflow logic stay in usb_key_queue.
// TESTING
//  1. Report keys={04,00,00,00}, mod=0 -> one entry 16'h0461; valid_o at T+2; pop -> empty.
//  2. Keys={04,05,06,00}, mod=02 -> entries 0441,0542,0643 in order; count_o=3.
//  3. Hold 04 (FIRST_REPEAT=20, REPEAT_RATE=5) -> repeats of 0461 at +20, then every +5.
//     Release -> no further repeats.
//  4. DEPTH=4, 6 new presses, no pops -> count_o=4, overflow_o=1, head=first press.
//     clr_ovf_i -> overflow_o=0.
//  5. Report {01,01,01,01} after holding 04 -> nothing queued; repeat of 04 continues.
//  6. Second report 1 cycle after first (NKEYS=4) -> processed after scan, no lost presses.
//     rst_n_i low mid-scan -> all outputs 0.

Source files
------------

// File: rtl/usb_hid_pkg.sv
// Shared HID types, constants and the scancode-to-character map for the USB keyboard path.
package usb_hid_pkg;

  typedef enum logic [1:0] {TYP_NONE = 2'd0, TYP_KBD = 2'd1, TYP_MOUSE = 2'd2, TYP_PAD = 2'd3} hid_typ_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} scan_st_e;

  // One queued key event: scancode in the high byte, character in the low byte.
  typedef struct packed {
    logic [7:0] sc;
    logic [7:0] ch;
  } key_evt_t;

  localparam logic [7:0] SHIFT_MASK   = 8'h22;
  localparam logic [7:0] CTRL_MASK    = 8'h11;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;
  localparam logic [7:0] ARROW_RIGHT  = 8'd136;
  localparam logic [7:0] ARROW_LEFT   = 8'd137;
  localparam logic [7:0] ARROW_DOWN   = 8'd138;
  localparam logic [7:0] ARROW_UP     = 8'd139;

  // Letters honour shift/ctrl, digits honour shift, a few control keys and arrows map to
  // fixed codes; anything else returns 0 so the scancode still reaches the CPU.
  function automatic logic [7:0] scancode2char(input logic [7:0] sc, input logic [7:0] mods);
    logic shift, ctrl;
    logic [7:0] ch;
    shift = |(mods & SHIFT_MASK);
    ctrl  = |(mods & CTRL_MASK);
    ch    = 8'h00;
    if (sc >= 8'h04 && sc <= 8'h1D) begin
      if (ctrl)       ch = sc - 8'h03;
      else if (shift) ch = 8'h41 + (sc - 8'h04);
      else            ch = 8'h61 + (sc - 8'h04);
    end else begin
      case (sc)
        8'h1E: ch = shift ? 8'h21 : 8'h31;
        8'h1F: ch = shift ? 8'h40 : 8'h32;
        8'h20: ch = shift ? 8'h23 : 8'h33;
        8'h21: ch = shift ? 8'h24 : 8'h34;
        8'h22: ch = shift ? 8'h25 : 8'h35;
        8'h23: ch = shift ? 8'h5E : 8'h36;
        8'h24: ch = shift ? 8'h26 : 8'h37;
        8'h25: ch = shift ? 8'h2A : 8'h38;
        8'h26: ch = shift ? 8'h28 : 8'h39;
        8'h27: ch = shift ? 8'h29 : 8'h30;
        8'h28: ch = 8'h0D;
        8'h29: ch = 8'h1B;
        8'h2A: ch = 8'h08;
        8'h2B: ch = 8'h09;
        8'h2C: ch = 8'h20;
        8'h4F: ch = ARROW_RIGHT;
        8'h50: ch = ARROW_LEFT;
        8'h51: ch = ARROW_DOWN;
        8'h52: ch = ARROW_UP;
        default: ch = 8'h00;
      endcase
    end
    return ch;
  endfunction

endpackage

// File: rtl/usb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head stays on rdata after the FIFO drains.
module usb_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clkusb_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] last;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? last : mem[rptr];

  // Storage write; contents need no reset since nothing is read before it is written.
  always_ff @(posedge clkusb_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
  always_ff @(posedge clkusb_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Remember the current head so rdata holds it once the FIFO empties.
  always_ff @(posedge clkusb_i or negedge rst_n_i) begin
    if (!rst_n_i)    last <= '0;
    else if (!empty) last <= mem[rptr];
  end

endmodule

// File: rtl/usb_key_queue.sv
// Keyboard event queue: scans HID reports for new presses, auto-repeats the last held key,
// and buffers {scancode, char} events for the CPU.
module usb_key_queue
  import usb_hid_pkg::*;
#(
  parameter int NKEYS        = 4,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 23,
  parameter int FIRST_REPEAT = 8000000,
  parameter int REPEAT_RATE  = 1200000,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int IW = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic               clkusb_i,
  input  logic               rst_n_i,
  input  logic               report_i,
  input  logic [1:0]         typ_i,
  input  logic [7:0]         key_modifiers_i,
  input  logic [8*NKEYS-1:0] keys_i,
  input  logic               repeat_en_i,
  input  logic               pop_i,
  input  logic               clr_ovf_i,
  output logic [15:0]        data_o,
  output logic               valid_o,
  output logic [CW-1:0]      count_o,
  output logic               overflow_o
);

  scan_st_e                st, st_nxt;
  logic [NKEYS-1:0][7:0]   snap_keys, pend_keys, prev_keys;
  logic [7:0]              snap_mod, pend_mod, prev_mod, rpt_key, rk_nxt, cur_sc;
  logic                    pend_vld, kbd, roll, acc, in_prev, rk_hit, is_last;
  logic                    new_press, rpt_fire, push, full, empty, drop;
  logic [CNT_W-1:0]        cnt;
  logic [IW-1:0]           idx;
  key_evt_t                evt;

  assign kbd      = (typ_i == TYP_KBD);
  assign acc      = report_i && kbd && !roll;
  assign cur_sc   = snap_keys[idx];
  assign is_last  = (idx == IW'(NKEYS-1));
  assign rpt_fire = (st == ST_IDLE) && (rpt_key != 8'h00) && repeat_en_i && (cnt <= CNT_W'(1));

  // Report qualification and slot lookups against the prev set and the snapshot.
  always_comb begin
    roll    = 1'b0;
    in_prev = 1'b0;
    rk_hit  = 1'b0;
    rk_nxt  = rpt_key;
    for (int k = 0; k < NKEYS; k++) begin
      if (keys_i[8*k +: 8] == KEY_ROLLOVER) roll = 1'b1;
      if (prev_keys[k] == cur_sc) in_prev = 1'b1;
    end
    new_press = (st == ST_SCAN) && (cur_sc != 8'h00) && !in_prev;
    if (new_press) rk_nxt = cur_sc;
    for (int k = 0; k < NKEYS; k++)
      if (snap_keys[k] == rk_nxt) rk_hit = 1'b1;
    if (is_last && !rk_hit) rk_nxt = 8'h00;
  end

  // FSM state register.
  always_ff @(posedge clkusb_i or negedge rst_n_i) begin
    if (!rst_n_i) st <= ST_IDLE;
    else          st <= st_nxt;
  end

  // FSM next state: losing the keyboard aborts any scan.
  always_comb begin
    st_nxt = st;
    if (!kbd) st_nxt = ST_IDLE;
    else begin
      case (st)
        ST_IDLE: if (acc || pend_vld) st_nxt = ST_SCAN;
        ST_SCAN: if (is_last) st_nxt = (acc || pend_vld) ? ST_SCAN : ST_IDLE;
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: a scan press or a repeat tick (never both, repeats only fire in IDLE).
  always_comb begin
    push = new_press || rpt_fire;
    if (new_press) evt = '{sc: cur_sc,  ch: scancode2char(cur_sc, snap_mod)};
    else           evt = '{sc: rpt_key, ch: scancode2char(rpt_key, prev_mod)};
  end

  // Scan datapath: snapshot/pending buffers, prev set, repeat key and repeat counter.
  always_ff @(posedge clkusb_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snap_keys <= '0; snap_mod <= '0; pend_keys <= '0; pend_mod <= '0; pend_vld <= 1'b0;
      prev_keys <= '0; prev_mod <= '0; rpt_key <= '0; idx <= '0;
      cnt <= CNT_W'(FIRST_REPEAT);
    end else if (!kbd) begin
      prev_keys <= '0;
      rpt_key   <= '0;
      pend_vld  <= 1'b0;
      idx       <= '0;
    end else if (st == ST_IDLE) begin
      idx <= '0;
      if (acc) begin
        snap_keys <= keys_i; snap_mod <= key_modifiers_i;
      end else if (pend_vld) begin
        snap_keys <= pend_keys; snap_mod <= pend_mod; pend_vld <= 1'b0;
      end
      if (rpt_key != 8'h00 && repeat_en_i)
        cnt <= rpt_fire ? CNT_W'(REPEAT_RATE) : cnt - 1'b1;
    end else begin
      rpt_key <= rk_nxt;
      if (new_press) cnt <= CNT_W'(FIRST_REPEAT);
      if (is_last) begin
        prev_keys <= snap_keys; prev_mod <= snap_mod; idx <= '0;
        if (acc) begin
          snap_keys <= keys_i; snap_mod <= key_modifiers_i;
        end else if (pend_vld) begin
          snap_keys <= pend_keys; snap_mod <= pend_mod;
        end
        pend_vld <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
        if (acc) begin
          pend_keys <= keys_i; pend_mod <= key_modifiers_i; pend_vld <= 1'b1;
        end
      end
    end
  end

  usb_sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clkusb_i (clkusb_i),
    .rst_n_i  (rst_n_i),
    .push     (push),
    .wdata    (evt),
    .pop      (pop_i),
    .rdata    (data_o),
    .full     (full),
    .empty    (empty),
    .count    (count_o)
  );

  assign valid_o = !empty;
  assign drop    = push && full && !pop_i;

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clkusb_i or negedge rst_n_i) begin
    if (!rst_n_i)       overflow_o <= 1'b0;
    else if (drop)      overflow_o <= 1'b1;
    else if (clr_ovf_i) overflow_o <= 1'b0;
  end

endmodule
